// File: rtl/pcie_ctrl_pkg.sv
// PCIe VC scheduler: shared state encoding,
// destination bit and threshold defaults.
package pcie_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int DEST_BIT = 5;

  localparam logic [1:0] DEF_UMB_MF = 2'd3;
  localparam logic [3:0] DEF_UMB_VC = 4'd12;
  localparam logic [1:0] DEF_UMB_D  = 2'd2;

  function automatic logic dest_afull(
    input logic [5:0] head,
    input logic       d0_af,
    input logic       d1_af
  );
    return head[DEST_BIT] ? d1_af : d0_af;
  endfunction

endpackage

// File: rtl/vc_wrr_arb.sv
// Weighted VC0/VC1 arbiter: VC0 wins ties until
// WEIGHT-1 wins in a row, then VC1 is forced once.
module vc_wrr_arb #(
  parameter int WEIGHT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic elig0,
  input  logic elig1,
  output logic gnt0,
  output logic gnt1
);

  localparam int W = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;
  localparam logic [W-1:0] LAST = W'(WEIGHT - 1);

  logic [W-1:0] wcnt;

  assign gnt1 = elig1 & (~elig0 | (wcnt == LAST));
  assign gnt0 = elig0 & ~gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
    end else if (!elig1 || gnt1) begin
      wcnt <= '0;
    end else if (gnt0) begin
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: rtl/vc_arbitro_ctrl.sv
// Control/scheduling for MF -> VC0/VC1 -> D0/D1:
// state sequencing, thresholds, arbitration, routing.
module vc_arbitro_ctrl #(
  parameter int         WEIGHT     = 4,
  parameter logic [1:0] DEF_UMB_MF = pcie_ctrl_pkg::DEF_UMB_MF,
  parameter logic [3:0] DEF_UMB_VC = pcie_ctrl_pkg::DEF_UMB_VC,
  parameter logic [1:0] DEF_UMB_D  = pcie_ctrl_pkg::DEF_UMB_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [1:0] umb_MF_in,
  input  logic [3:0] umb_VC0_in,
  input  logic [3:0] umb_VC1_in,
  input  logic [1:0] umb_D0_in,
  input  logic [1:0] umb_D1_in,
  input  logic [5:0] vc0_head,
  input  logic [5:0] vc1_head,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       vc0_afull,
  input  logic       vc1_afull,
  input  logic       d0_afull,
  input  logic       d1_afull,
  input  logic [4:0] fifo_err,
  input  logic       all_empty,
  output logic       vc0_pop,
  output logic       vc1_pop,
  output logic       d0_push,
  output logic       d1_push,
  output logic [5:0] data_out,
  output logic [1:0] umbral_MF,
  output logic [3:0] umbral_VC0,
  output logic [3:0] umbral_VC1,
  output logic [1:0] umbral_D0,
  output logic [1:0] umbral_D1,
  output logic       Pausa_MF,
  output logic       active_out,
  output logic       idle_out,
  output logic       error_out
);

  import pcie_ctrl_pkg::*;

  state_t state_q;
  state_t state_d;

  logic err;
  logic run;
  logic in_flight;
  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;

  assign err       = |fifo_err;
  assign in_flight = d0_push | d1_push;

  // init or a fresh error stops popping in the same cycle
  assign run = (state_q == ST_ACTIVE) & ~init & ~err;

  assign elig0 = run & ~vc0_empty
               & ~dest_afull(vc0_head, d0_afull, d1_afull);
  assign elig1 = run & ~vc1_empty
               & ~dest_afull(vc1_head, d0_afull, d1_afull);

  vc_wrr_arb #(
    .WEIGHT (WEIGHT)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .elig0 (elig0),
    .elig1 (elig1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign vc0_pop = gnt0;
  assign vc1_pop = gnt1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        if (err)
          state_d = ST_ERROR;
        else if (!init)
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (err)
          state_d = ST_ERROR;
        else if (init)
          state_d = ST_INIT;
        else if (!vc0_empty || !vc1_empty)
          state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err)
          state_d = ST_ERROR;
        else if (init)
          state_d = ST_INIT;
        else if (all_empty && !in_flight)
          state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!err && init)
          state_d = ST_INIT;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_out <= (state_d == ST_ACTIVE);
      idle_out   <= (state_d == ST_IDLE);
      error_out  <= (state_d == ST_ERROR);
    end
  end

  // output stage: one word per cycle, routed by its head bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
    end else begin
      d0_push <= (gnt0 & ~vc0_head[DEST_BIT])
               | (gnt1 & ~vc1_head[DEST_BIT]);
      d1_push <= (gnt0 & vc0_head[DEST_BIT])
               | (gnt1 & vc1_head[DEST_BIT]);
      if (gnt0)
        data_out <= vc0_head;
      else if (gnt1)
        data_out <= vc1_head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Pausa_MF <= 1'b0;
    end else if (state_q != ST_RESET) begin
      Pausa_MF <= vc0_afull | vc1_afull;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      umbral_MF  <= DEF_UMB_MF;
      umbral_VC0 <= DEF_UMB_VC;
      umbral_VC1 <= DEF_UMB_VC;
      umbral_D0  <= DEF_UMB_D;
      umbral_D1  <= DEF_UMB_D;
    end else if (state_q == ST_INIT && init) begin
      umbral_MF  <= umb_MF_in;
      umbral_VC0 <= umb_VC0_in;
      umbral_VC1 <= umb_VC1_in;
      umbral_D0  <= umb_D0_in;
      umbral_D1  <= umb_D1_in;
    end
  end

endmodule

// File: tb/tb_vc_arbitro_ctrl.sv
// Bench for vc_arbitro_ctrl: VC FIFOs kept as queues,
// outputs compared each cycle to a behavioural model.
module tb_vc_arbitro_ctrl;

  localparam int WEIGHT = 4;
  localparam int M_RST = 0;
  localparam int M_INIT = 1;
  localparam int M_IDLE = 2;
  localparam int M_ACT = 3;
  localparam int M_ERR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [1:0] umb_MF_in;
  logic [3:0] umb_VC0_in;
  logic [3:0] umb_VC1_in;
  logic [1:0] umb_D0_in;
  logic [1:0] umb_D1_in;
  logic [5:0] vc0_head;
  logic [5:0] vc1_head;
  logic       vc0_empty;
  logic       vc1_empty;
  logic       vc0_afull;
  logic       vc1_afull;
  logic       d0_afull;
  logic       d1_afull;
  logic [4:0] fifo_err;
  logic       all_empty;
  logic       vc0_pop;
  logic       vc1_pop;
  logic       d0_push;
  logic       d1_push;
  logic [5:0] data_out;
  logic [1:0] umbral_MF;
  logic [3:0] umbral_VC0;
  logic [3:0] umbral_VC1;
  logic [1:0] umbral_D0;
  logic [1:0] umbral_D1;
  logic       Pausa_MF;
  logic       active_out;
  logic       idle_out;
  logic       error_out;

  vc_arbitro_ctrl #(.WEIGHT(WEIGHT)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .umb_MF_in  (umb_MF_in),
    .umb_VC0_in (umb_VC0_in),
    .umb_VC1_in (umb_VC1_in),
    .umb_D0_in  (umb_D0_in),
    .umb_D1_in  (umb_D1_in),
    .vc0_head   (vc0_head),
    .vc1_head   (vc1_head),
    .vc0_empty  (vc0_empty),
    .vc1_empty  (vc1_empty),
    .vc0_afull  (vc0_afull),
    .vc1_afull  (vc1_afull),
    .d0_afull   (d0_afull),
    .d1_afull   (d1_afull),
    .fifo_err   (fifo_err),
    .all_empty  (all_empty),
    .vc0_pop    (vc0_pop),
    .vc1_pop    (vc1_pop),
    .d0_push    (d0_push),
    .d1_push    (d1_push),
    .data_out   (data_out),
    .umbral_MF  (umbral_MF),
    .umbral_VC0 (umbral_VC0),
    .umbral_VC1 (umbral_VC1),
    .umbral_D0  (umbral_D0),
    .umbral_D1  (umbral_D1),
    .Pausa_MF   (Pausa_MF),
    .active_out (active_out),
    .idle_out   (idle_out),
    .error_out  (error_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  bit         pop_log[$];
  logic [6:0] push_log[$];
  bit         log_en = 1'b0;

  int         m_mode;
  int         m_streak;
  bit         m_d0, m_d1, m_pausa;
  logic [5:0] m_data;
  logic [1:0] m_umf, m_ud0, m_ud1;
  logic [3:0] m_uv0, m_uv1;

  int         n_mode;
  int         n_streak;
  bit         n_d0, n_d1, n_pausa, n_pop0, n_pop1;
  logic [5:0] n_data;
  logic [1:0] n_umf, n_ud0, n_ud1;
  logic [3:0] n_uv0, n_uv1;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_RST; m_streak = 0;
    m_d0 = 0; m_d1 = 0; m_pausa = 0; m_data = '0;
    m_umf = 2'd3; m_uv0 = 4'd12; m_uv1 = 4'd12;
    m_ud0 = 2'd2; m_ud1 = 2'd2;
  endtask

  task automatic refresh();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_head  = vc0_empty ? 6'(
$urandom) : q0[0];
    vc1_head  = vc1_empty ? 6'($urandom) : q1[0];
    all_empty = vc0_empty && vc1_empty;
  endtask

  task automatic plan_and_check();
    bit run, e0, e1, p0, p1, err, anyq, blk0, blk1;
    err  = (fifo_err != 0);
    anyq = (q0.size() > 0) || (q1.size() > 0);
    run  = (m_mode == M_ACT) && !init && !err;
    blk0 = vc0_head[5] ? d1_afull : d0_afull;
    blk1 = vc1_head[5] ? d1_afull : d0_afull;
    e0 = run && (q0.size() > 0) && !blk0;
    e1 = run && (q1.size() > 0) && !blk1;
    if (e0 && e1) begin
      p1 = (m_streak == WEIGHT - 1);
      p0 = !p1;
    end else begin
      p0 = e0;
      p1 = e1;
    end
    chk("vc0_pop", 8'(vc0_pop), 8'(p0));
    chk("vc1_pop", 8'(vc1_pop), 8'(p1));
    chk("d0_push", 8'(d0_push), 8'(m_d0));
    chk("d1_push", 8'(d1_push), 8'(m_d1));
    if (m_d0 || m_d1) chk("data_out", 8'(data_out), 8'(m_data));
    chk("active_out", 8'(active_out), 8'(m_mode == M_ACT));
    chk("idle_out", 8'(idle_out), 8'(m_mode == M_IDLE));
    chk("error_out", 8'(error_out), 8'(m_mode == M_ERR));
    chk("pausa_mf", 8'(Pausa_MF), 8'(m_pausa));
    chk("umbral_mf", 8'(umbral_MF), 8'(m_umf));
    chk("umbral_vc0", 8'(umbral_VC0), 8'(m_uv0));
    chk("umbral_vc1", 8'(umbral_VC1), 8'(m_uv1));
    chk("umbral_d0", 8'(umbral_D0), 8'(m_ud0));
    chk("umbral_d1", 8'(umbral_D1), 8'(m_ud1));
    if (log_en) begin
      if (vc0_pop) pop_log.push_back(1'b0);
      if (vc1_pop) pop_log.push_back(1'b1);
      if (d0_push || d1_push) push_log.push_back({d1_push, data_out});
    end
    n_pop0 = p0;
    n_pop1 = p1;
    n_streak = (!e1 || p1) ? 0 : (p0 ? m_streak + 1 : m_streak);
    n_d0 = (p0 && !vc0_head[5]) || (p1 && !vc1_head[5]);
    n_d1 = (p0 && vc0_head[5]) || (p1 && vc1_head[5]);
    n_data = p0 ? vc0_head : (p1 ? vc1_head : m_data);
    n_pausa = (m_mode != M_RST) ? (vc0_afull | vc1_afull) : m_pausa;
    if (m_mode == M_INIT && init) begin
      n_umf = umb_MF_in; n_uv0 = umb_VC0_in; n_uv1 = umb_VC1_in;
      n_ud0 = umb_D0_in; n_ud1 = umb_D1_in;
    end else begin
      n_umf = m_umf; n_uv0 = m_uv0; n_uv1 = m_uv1;
      n_ud0 = m_ud0; n_ud1 = m_ud1;
    end
    case (m_mode)
      M_RST:  n_mode = M_INIT;
      M_INIT: n_mode = err ? M_ERR : (!init ? M_IDLE : M_INIT);
      M_IDLE: n_mode = err ? M_ERR : init ? M_INIT
                     : (anyq ? M_ACT : M_IDLE);
      M_ACT:  n_mode = err ? M_ERR : init ? M_INIT
                     : ((all_empty && !(m_d0 || m_d1)) ? M_IDLE : M_ACT);
      default: n_mode = (!err && init) ? M_INIT : M_ERR;
    endcase
  endtask

  task automatic commit();
    if (reset) begin
      model_reset();
    end else begin
      m_mode = n_mode; m_streak = n_streak;
      m_d0 = n_d0; m_d1 = n_d1; m_data = n_data; m_pausa = n_pausa;
      m_umf = n_umf; m_uv0 = n_uv0; m_uv1 = n_uv1;
      m_ud0 = n_ud0; m_ud1 = n_ud1;
      if (n_pop0) void'(q0.pop_front());
      if (n_pop1) void'(q1.pop_front());
    end
  endtask

  task automatic step();
    refresh();
    @(negedge clk);
    plan_and_check();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic wait_idle(string name, int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (m_mode == M_IDLE && q0.size() == 0 && q1.size() == 0) break;
    end
    chk(name, 8'(idle_out), 8'd1);
  endtask

  task automatic wait_active(string name, int max);
    for (int i = 0; i < max; i++) begin
      if (m_mode == M_ACT) break;
      step();
    end
    chk(name, 8'(active_out), 8'd1);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    push_log.delete();
  endtask

  function automatic int count_pops(bit which);
    int n = 0;
    foreach (pop_log[i]) if (pop_log[i] == which) n++;
    return n;
  endfunction

  initial begin
    bit exp_pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    model_reset();
    reset = 1'b1; init = 1'b0;
    umb_MF_in = 2'd1; umb_VC0_in = 4'd5; umb_VC1_in = 4'd7;
    umb_D0_in = 2'd1; umb_D1_in = 2'd3;
    vc0_afull = 0; vc1_afull = 0; d0_afull = 0; d1_afull = 0;
    fifo_err = '0;
    refresh();
    #1;
    chk("rst_umb_vc0", 8'(umbral_VC0), 8'd12);
    chk("rst_idle", 8'(idle_out), 8'd0);
    @(posedge clk); #1;
    step(); step();

    // 1: init sequence
    reset = 1'b0;
    step();
    init = 1'b1;
    step();
    chk("t1_umb_vc0", 8'(umbral_VC0), 8'd5);
    step();
    init = 1'b0;
    step();
    step();
    chk("t1_idle", 8'(idle_out), 8'd1);

    // 2: three words on VC0 only
    q0.push_back(6'h05); q0.push_back(6'h25); q0.push_back(6'h01);
    clear_logs(); log_en = 1;
    wait_idle("t2_idle", 30);
    log_en = 0;
    chk("t2_npush", 8'(push_log.size()), 8'd3);
    if (push_log.size() == 3) begin
      chk("t2_push0", 8'(push_log[0]), 8'h05);
      chk("t2_push1", 8'(push_log[1]), 8'h65);
      chk("t2_push2", 8'(push_log[2]), 8'h01);
    end
    chk("t2_vc1_pops", 8'(count_pops(1)), 8'd0);

    // 3: both VCs loaded, weighted pattern
    for (int i = 0; i < 12; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    clear_logs(); log_en = 1;
    wait_idle("t3_idle", 60);
    log_en = 0;
    chk("t3_npop", 8'(pop_log.size()), 8'd24);
    if (pop_log.size() >= 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("t3_grant%0d", i), 8'(pop_log[i]), 8'(exp_pat[i]));

    // 4: VC0 blocked by d1_afull
    d1_afull = 1;
    q0.push_back(6'h20);
    q1.push_back(6'h03); q1.push_back(6'h04); q1.push_back(6'h05);
    clear_logs(); log_en = 1;
    for (int i = 0; i < 6; i++) step();
    chk("t4_vc0_blocked", 8'(count_pops(0)), 8'd0);
    chk("t4_vc1_pops", 8'(count_pops(1)), 8'd3);
    d1_afull = 0;
    wait_idle("t4_idle", 20);
    log_en = 0;
    chk("t4_vc0_after", 8'(count_pops(0)), 8'd1);

    // 5: error and recovery
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    wait_active("t5_active", 10);
    step();
    fifo_err = 5'b00100;
    step();
    fifo_err = '0;
    chk("t5_error", 8'(error_out), 8'd1);
    clear_logs(); log_en = 1;
    step(); step(); step();
    log_en = 0;
    chk("t5_no_pops", 8'(pop_log.size()), 8'd0);
    chk("t5_no_push", 8'(push_log.size()), 8'd0);
    init = 1;
    step();
    init = 0;
    chk("t5_err_clear", 8'(error_out), 8'd0);
    wait_idle("t5_idle", 60);

    // 6: async reset mid-burst
    for (int i = 0; i < 10; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    wait_active("t6_active", 10);
    step(); step();
    #2 reset = 1;
    #1;
    chk("t6_push", 8'({d0_push, d1_push}), 8'd0);
    chk("t6_pop", 8'({vc0_pop, vc1_pop}), 8'd0);
    chk("t6_data", 8'(data_out), 8'd0);
    chk("t6_status", 8'({active_out, idle_out, error_out}), 8'd0);
    chk("t6_umb_vc0", 8'(umbral_VC0), 8'd12);
    chk("t6_umb_mf", 8'(umbral_MF), 8'd3);
    chk("t6_umb_d1", 8'(umbral_D1), 8'd2);
    model_reset();
    @(posedge clk); #1;
    step();
    reset = 0;
    step();
    wait_idle("t6_idle", 60);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2) == 0 && q0.size() < 16)
        q0.push_back(6'($urandom));
      if ($urandom_range(2) == 0 && q1.size() < 16)
        q1.push_back(6'($urandom));
      d0_afull  = ($urandom_range(3) == 0);
      d1_afull  = ($urandom_range(3) == 0);
      vc0_afull = ($urandom_range(4) == 0);
      vc1_afull = ($urandom_range(4) == 0);
      fifo_err  = ($urandom_range(59) == 0) ? 5'($urandom_range(31, 1)) : '0;
      init = ($urandom_range(39) == 0)
          || (m_mode == M_ERR && $urandom_range(3) == 0)
          || (m_mode == M_INIT && $urandom_range(1) == 0);
      umb_MF_in  = 2'($urandom);
      umb_VC0_in = 4'($urandom);
      umb_VC1_in = 4'($urandom);
      umb_D0_in  = 2'($urandom);
      umb_D1_in  = 2'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
